// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx arbiter slice.
//   arb_state_t : arbiter FSM states (ST_IDLE, ST_STREAM)
//   clog2       : ceiling log2, usable in constant expressions for port widths
package uart_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } arb_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector.
//   req    : request vector
//   rr_ptr : highest-priority index for this search
//   found  : at least one request is set
//   index  : first set request at or after rr_ptr, wrapping past NUM_REQ-1
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                      found,
  output logic [clog2(NUM_REQ)-1:0] index
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     offset;
  logic [IDX_W:0]       sum;

  // Rotate so rr_ptr lands at bit 0, take the lowest set bit, then rotate the
  // offset back; the subtract handles NUM_REQ values that are not powers of two.
  always_comb begin
    dbl    = {req, req} >> rr_ptr;
    rot    = dbl[NUM_REQ-1:0];
    found  = 1'b0;
    offset = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (rot[k] && !found) begin
        found  = 1'b1;
        offset = IDX_W'(k);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
    index = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_tx among NUM_REQ
// byte-stream requesters. A grant is held until the last byte is accepted,
// the MAX_PKT_LEN cap is hit, or the granted requester stalls STALL_CYCLES.
//   clk, rst_n    : clock, asynchronous active-low reset
//   req_valid/req_data/req_last/req_ready : per-requester byte streams
//   tx_data/tx_data_valid/tx_data_ready   : to/from uart_tx
//   grant_id      : current or most recent grant
//   busy          : grant held
//   stall_err     : one-cycle pulse, grant aborted by stall watchdog
//   len_err       : one-cycle pulse, grant released by length cap
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_PKT_LEN  = 64,
  parameter int unsigned STALL_CYCLES = 27000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_data_valid,
  input  logic                          tx_data_ready,
  output logic [clog2(NUM_REQ)-1:0]     grant_id,
  output logic                          busy,
  output logic                          stall_err,
  output logic                          len_err
);

  localparam int unsigned IDX_W   = clog2(NUM_REQ);
  localparam int unsigned LEN_W   = clog2(MAX_PKT_LEN + 1);
  localparam int unsigned STALL_W = clog2(STALL_CYCLES + 1);
  localparam logic [LEN_W-1:0]   LEN_LAST   = LEN_W'(MAX_PKT_LEN - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

  arb_state_t           state, state_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]     grant_nxt, grant_inc, pick_idx;
  logic                 pick_found;
  logic [LEN_W-1:0]     byte_cnt, byte_cnt_nxt;
  logic [STALL_W-1:0]   stall_cnt, stall_cnt_nxt;
  logic                 stall_err_nxt, len_err_nxt;
  logic [DATA_WIDTH-1:0] g_data;
  logic                 g_valid, g_last, hs;

  uart_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req   (req_valid),
    .rr_ptr(rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  // Granted requester's stream, selected by grant_id.
  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDX_W'(i)) begin
        g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        g_valid = req_valid[i];
        g_last  = req_last[i];
      end
    end
  end

  assign grant_inc = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant_id;
    byte_cnt_nxt  = byte_cnt;
    stall_cnt_nxt = stall_cnt;
    stall_err_nxt = 1'b0;
    len_err_nxt   = 1'b0;
    tx_data       = '0;
    tx_data_valid = 1'b0;
    req_ready     = '0;
    hs            = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        tx_data       = g_data;
        tx_data_valid = g_valid;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (grant_id == IDX_W'(i)) && tx_data_ready;
        end
        hs = g_valid && tx_data_ready;

        if (hs) begin
          stall_cnt_nxt = '0;
          byte_cnt_nxt  = byte_cnt + 1'b1;
          // A last byte that also hits the cap is a normal release.
          if (g_last || byte_cnt == LEN_LAST) begin
            state_nxt    = ST_IDLE;
            rr_ptr_nxt   = grant_inc;
            byte_cnt_nxt = '0;
            len_err_nxt  = !g_last;
          end
        end else if (!g_valid) begin
          // Waiting on tx_data_ready with valid high is not a stall.
          if (stall_cnt == STALL_LAST) begin
            state_nxt     = ST_IDLE;
            rr_ptr_nxt    = grant_inc;
            byte_cnt_nxt  = '0;
            stall_cnt_nxt = '0;
            stall_err_nxt = 1'b1;
          end else begin
            stall_cnt_nxt = stall_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      byte_cnt  <= '0;
      stall_cnt <= '0;
      stall_err <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_id  <= grant_nxt;
      byte_cnt  <= byte_cnt_nxt;
      stall_cnt <= stall_cnt_nxt;
      stall_err <= stall_err_nxt;
      len_err   <= len_err_nxt;
    end
  end

  assign busy = (state == ST_STREAM);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a transaction-level reference model
// pushes expected bytes and error pulses; a monitor pops them as the DUT
// presents handshakes and pulses.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int MAX_LEN = 64;
  localparam int STALL   = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0] tx_data;
  logic          tx_data_valid, tx_data_ready;
  logic [1:0]    grant_id;
  logic          busy, stall_err, len_err;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_PKT_LEN(MAX_LEN), .STALL_CYCLES(STALL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .grant_id(grant_id), .busy(busy), .stall_err(stall_err), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_BYTE, EV_STALL, EV_LEN} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       id;
    int       data;
  } ev_t;

  ev_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Requester-side stimulus state: pending bytes as {last, data}.
  int  bq [N][$];
  int  pause [N];
  bit  stall_after_first [N];
  int  rdy_period = 1;
  bit  rdy_random = 0;
  int  gap_max    = 0;
  bit  rand_stall = 0;
  int  cyc        = 0;

  // Reference model state.
  int  m_owner  = -1;
  int  m_rr     = 0;
  int  m_bytes  = 0;
  int  m_stalls = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input int id, input int data);
    ev_t e;
    e.kind = k; e.id = id; e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input int id, input int data);
    ev_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got %s id=%0d data=%02h, expected none", k.name(), id, data);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != k || e.id != id || e.data != data) begin
        n_bad++;
        $display("FAIL event: got %s id=%0d data=%02h, expected %s id=%0d data=%02h",
                 k.name(), id, data, e.kind.name(), e.id, e.data);
      end else if (k == EV_BYTE) begin
        cmp("req_ready_onehot", int'(req_ready), 1 << e.id);
        cmp("busy_during_byte", int'(busy), 1);
      end
    end
  endtask

  task automatic push_pkt(input int r, input int len, input int first, input bit with_last,
                          input bit rnd);
    int v;
    for (int k = 0; k < len; k++) begin
      v = rnd ? int'($urandom_range(255, 0)) : ((first + k) & 255);
      if (with_last && k == len - 1) v = v | 256;
      bq[r].push_back(v);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_tx_data"}, int'(tx_data), 0);
    cmp({tag, "_tx_data_valid"}, int'(tx_data_valid), 0);
    cmp({tag, "_req_ready"}, int'(req_ready), 0);
    cmp({tag, "_grant_id"}, int'(grant_id), 0);
    cmp({tag, "_busy"}, int'(busy), 0);
    cmp({tag, "_stall_err"}, int'(stall_err), 0);
    cmp({tag, "_len_err"}, int'(len_err), 0);
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk); #2;
      done = (m_owner < 0) && (sb_q.size() == 0);
      for (int i = 0; i < N; i++) if (bq[i].size() != 0) done = 0;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_%s: got not drained after %0d cycles, expected drained", name, budget);
    end
  endtask

  // Requester and uart_tx models.
  initial begin : driver
    logic [N-1:0] acc;
    int v;
    req_valid = '0; req_last = '0; req_data = '0; tx_data_ready = 1'b0;
    for (int i = 0; i < N; i++) begin pause[i] = 0; stall_after_first[i] = 0; end
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready & {N{rst_n}};
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          void'(bq[i].pop_front());
          if (stall_after_first[i]) begin
            pause[i] = STALL + 5;
            stall_after_first[i] = 0;
          end else if (rand_stall && $urandom_range(39, 0) == 0) begin
            pause[i] = int'($urandom_range(STALL + 3, STALL - 3));
          end else begin
            pause[i] = int'($urandom_range(gap_max, 0));
          end
        end
        if (pause[i] > 0) begin
          pause[i]--;
          req_valid[i] = 1'b0;
        end else if (bq[i].size() > 0) begin
          v = bq[i][0];
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = v[7:0];
          req_last[i] = v[8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      tx_data_ready = rdy_random ? ($urandom_range(2, 0) == 0) : ((cyc % rdy_period) == 0);
    end
  end

  // Reference model: one grant at a time, round-robin from the slot after the
  // last released owner; predicts each accepted byte and each error pulse.
  initial begin : model
    int c;
    int g;
    bit f;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_owner = -1; m_rr = 0; m_bytes = 0; m_stalls = 0;
        sb_q.delete();
      end else if (m_owner < 0) begin
        f = 0;
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (!f && req_valid[c]) begin
            f = 1;
            m_owner = c;
            m_bytes = 0;
            m_stalls = 0;
          end
        end
      end else begin
        g = m_owner;
        if (req_valid[g] && tx_data_ready) begin
          push_ev(EV_BYTE, g, int'(req_data[g*DW +: DW]));
          m_bytes++;
          m_stalls = 0;
          if (req_last[g] || m_bytes == MAX_LEN) begin
            if (!req_last[g]) push_ev(EV_LEN, g, 0);
            m_owner = -1;
            m_rr = (g + 1) % N;
          end
        end else if (!req_valid[g]) begin
          m_stalls++;
          if (m_stalls == STALL) begin
            push_ev(EV_STALL, g, 0);
            m_owner = -1;
            m_rr = (g + 1) % N;
          end
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk); #1;
      if (rst_n) begin
        if (tx_data_valid && tx_data_ready) observe(EV_BYTE, int'(grant_id), int'(tx_data));
        if (stall_err) observe(EV_STALL, int'(grant_id), 0);
        if (len_err) observe(EV_LEN, int'(grant_id), 0);
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit seen;
    int r;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // Single requester, slow uart.
    rdy_period = 10;
    @(posedge clk); #2;
    push_pkt(0, 3, 'h41, 1, 0);
    wait_drain(400, "single");

    // Three requesters contending with 2-byte packets; req0 has two.
    rdy_period = 1;
    @(posedge clk); #2;
    push_pkt(0, 2, 'h10, 1, 0);
    push_pkt(0, 2, 'h18, 1, 0);
    push_pkt(1, 2, 'h20, 1, 0);
    push_pkt(2, 2, 'h30, 1, 0);
    wait_drain(400, "contend");

    // req1 stalls mid-packet while req2 waits.
    @(posedge clk); #2;
    stall_after_first[1] = 1;
    push_pkt(1, 3, 'h50, 1, 0);
    repeat (4) @(posedge clk);
    #2 push_pkt(2, 2, 'h60, 1, 0);
    wait_drain(600, "stall");

    // req3 exceeds the length cap while req0 waits.
    @(posedge clk); #2;
    push_pkt(3, 70, 'h80, 1, 0);
    repeat (4) @(posedge clk);
    #2 push_pkt(0, 2, 'h70, 1, 0);
    wait_drain(1000, "len_cap");

    // Last byte coincides with the cap: no len_err.
    @(posedge clk); #2;
    push_pkt(2, MAX_LEN, 'h01, 1, 0);
    wait_drain(800, "len_exact");

    // Randomized traffic with gaps, stalls around the watchdog threshold
    // and a random uart ready pattern.
    gap_max = 2; rand_stall = 1; rdy_random = 1;
    for (int it = 0; it < 250; it++) begin
      @(posedge clk); #2;
      r = int'($urandom_range(N - 1, 0));
      if (bq[r].size() < 8) push_pkt(r, int'($urandom_range(6, 1)), 0, 1, 1);
      repeat ($urandom_range(4, 0)) @(posedge clk);
    end
    wait_drain(30000, "random");

    // Reset in the middle of a packet.
    gap_max = 0; rand_stall = 0; rdy_random = 0; rdy_period = 3;
    @(posedge clk); #2;
    push_pkt(2, 10, 'hA0, 1, 0);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk); #1;
      seen = tx_data_valid;
    end
    cmp("midpkt_valid_seen", int'(seen), 1);
    @(posedge clk); #2 rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin bq[i].delete(); pause[i] = 0; end
    #1 check_reset_outputs("midpkt_reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    push_pkt(3, 1, 'hD3, 1, 0);
    push_pkt(1, 1, 'hD1, 1, 0);
    wait_drain(200, "post_reset");

    cmp("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
